// File: rtl/abc_mul8_pkg.sv
// abc_mul8 shared types and constants.
// FSM encoding and fixed operand/result widths.
package abc_mul8_pkg;

  localparam int OP_W      = 8;
  localparam int RES_W     = 16;
  localparam int MUL_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2,
    REL  = 2'd3
  } state_t;

endpackage

// File: rtl/abc_mul8_mul8_seq.sv
// mul8_seq: sequential shift-and-add 8x8 unsigned core.
// start loads operands; done pulses one cycle once p is final.
module mul8_seq
  import abc_mul8_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             done,
  output logic [RES_W-1:0] p
);

  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] mcand;
  logic [OP_W-1:0]  mplier;
  logic [3:0]       cnt;
  logic             busy;

  assign p = acc;

  // one multiplier bit per cycle; acc holds its value after done
  always_ff @(posedge clock) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= '0;
        mcand  <= {{(RES_W-OP_W){1'b0}}, a};
        mplier <= b;
        cnt    <= 4'(MUL_STEPS);
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0])
          acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/abc_mul8.sv
// abc_mul8: two-channel handshaked 8x8 unsigned multiplier.
// Captures both operands, multiplies, strobes ok with m.
module abc_mul8
  import abc_mul8_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [OP_W-1:0]  x,
  input  logic             dav1_,
  output logic             rfd1,
  input  logic [OP_W-1:0]  y,
  input  logic             dav2_,
  output logic             rfd2,
  output logic [RES_W-1:0] m,
  output logic             ok
);

  state_t           state;
  state_t           next;
  logic [OP_W-1:0]  xq;
  logic [OP_W-1:0]  yq;
  logic             cap1;
  logic             cap2;
  logic             start;
  logic             core_done;
  logic [RES_W-1:0] prod;
  logic             release_ok;

  assign release_ok = (state == REL) && dav1_ && dav2_;

  // ok is a pure state decode so it is high for DONE only
  assign ok = (state == DONE);

  mul8_seq u_core (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a     (xq),
    .b     (yq),
    .done  (core_done),
    .p     (prod)
  );

  // next-state and core start
  always_comb begin
    next  = state;
    start = 1'b0;
    unique case (state)
      IDLE: begin
        if (cap1 && cap2) begin
          next  = MUL;
          start = 1'b1;
        end
      end
      MUL:     if (core_done) next = DONE;
      DONE:    next = REL;
      REL:     if (dav1_ && dav2_) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // channel 1: capture once, re-arm only after both producers let go
  always_ff @(posedge clock) begin
    if (reset) begin
      rfd1 <= 1'b1;
      cap1 <= 1'b0;
      xq   <= '0;
    end else if (release_ok) begin
      rfd1 <= 1'b1;
      cap1 <= 1'b0;
    end else if (rfd1 && !dav1_) begin
      xq   <= x;
      rfd1 <= 1'b0;
      cap1 <= 1'b1;
    end
  end

  // channel 2: same handshake as channel 1
  always_ff @(posedge clock) begin
    if (reset) begin
      rfd2 <= 1'b1;
      cap2 <= 1'b0;
      yq   <= '0;
    end else if (release_ok) begin
      rfd2 <= 1'b1;
      cap2 <= 1'b0;
    end else if (rfd2 && !dav2_) begin
      yq   <= y;
      rfd2 <= 1'b0;
      cap2 <= 1'b1;
    end
  end

  // m is loaded on the edge entering DONE so it is valid as ok rises
  always_ff @(posedge clock) begin
    if (reset)
      m <= '0;
    else if (state == MUL && core_done)
      m <= prod;
  end

endmodule

// File: tb/tb_abc_mul8.sv
// tb_abc_mul8: directed self-checking bench for abc_mul8.
// Counts ok rising edges and checks m against hand values.
module tb_abc_mul8;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  x;
  logic        dav1_;
  logic        rfd1;
  logic [7:0]  y;
  logic        dav2_;
  logic        rfd2;
  logic [15:0] m;
  logic        ok;

  int checks = 0;
  int errors = 0;
  int ok_count = 0;
  logic [15:0] last_m = '0;
  logic ok_prev = 1'b0;

  always #5 clock = ~clock;

  abc_mul8 dut (
    .clock (clock),
    .reset (reset),
    .x     (x),
    .dav1_ (dav1_),
    .rfd1  (rfd1),
    .y     (y),
    .dav2_ (dav2_),
    .rfd2  (rfd2),
    .m     (m),
    .ok    (ok)
  );

  // ok edge monitor, sampled just after the active edge
  always @(posedge clock) begin
    #1;
    if (ok === 1'b1 && ok_prev !== 1'b1) begin
      ok_count++;
      last_m = m;
    end
    ok_prev = ok;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rfd(input logic w1, input logic w2,
                          input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (rfd1 === w1 && rfd2 === w2) break;
    end
    check(tag, {30'd0, rfd1, rfd2}, {30'd0, w1, w2});
  endtask

  task automatic wait_ok(input int base, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ok_count != base) break;
    end
    check(tag, ok_count, base + 1);
  endtask

  task automatic run_pair(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string tag);
    int base;
    base = ok_count;
    @(negedge clock);
    x = a; y = b; dav1_ = 1'b0; dav2_ = 1'b0;
    wait_rfd(1'b0, 1'b0, {tag, " cap"});
    repeat (3) @(negedge clock);
    dav1_ = 1'b1; dav2_ = 1'b1; x = 'x; y = 'x;
    wait_rfd(1'b1, 1'b1, {tag, " rel"});
    check({tag, " okcnt"}, ok_count, base + 1);
    check({tag, " m"}, last_m, exp);
  endtask

  initial begin
    int base;
    reset = 1'b1; dav1_ = 1'b1; dav2_ = 1'b1; x = '0; y = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst rfd1", rfd1, 1);
    check("rst rfd2", rfd2, 1);
    check("rst ok", ok, 0);
    check("rst m", m, 0);

    // simultaneous pair, dav held past ok
    base = ok_count;
    x = 8'd5; y = 8'd28; dav1_ = 1'b0; dav2_ = 1'b0;
    wait_rfd(1'b0, 1'b0, "t2 cap");
    wait_ok(base, "t2 ok");
    check("t2 m", last_m, 140);
    check("t2 hold", {rfd1, rfd2}, 0);
    dav1_ = 1'b1;
    repeat (3) @(negedge clock);
    check("t2 one rel", {rfd1, rfd2}, 0);
    dav2_ = 1'b1;
    wait_rfd(1'b1, 1'b1, "t2 rel");
    check("t2 okcnt", ok_count, base + 1);

    // staggered operands
    base = ok_count;
    x = 8'd80; dav1_ = 1'b0;
    wait_rfd(1'b0, 1'b1, "t3 cap1");
    repeat (3) @(negedge clock);
    dav1_ = 1'b1; x = 'x;
    repeat (2) @(negedge clock);
    check("t3 no ok", ok_count, base);
    check("t3 rfd", {rfd1, rfd2}, 1);
    y = 8'd49; dav2_ = 1'b0;
    wait_rfd(1'b0, 1'b0, "t3 cap2");
    repeat (3) @(negedge clock);
    dav2_ = 1'b1; y = 'x;
    wait_rfd(1'b1, 1'b1, "t3 rel");
    check("t3 okcnt", ok_count, base + 1);
    check("t3 m", last_m, 3920);

    // corners
    run_pair(8'd0, 8'd200, 16'd0, "c0x200");
    run_pair(8'd255, 8'd255, 16'd65025, "c255x255");
    run_pair(8'd1, 8'd255, 16'd255, "c1x255");

    // sweep
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 4; j++)
        run_pair(8'((k + 1) * 5), 8'((j + 4) * 7),
                 16'((k + 1) * 5 * (j + 4) * 7), "sweep");

    // reset while multiplying
    base = ok_count;
    @(negedge clock);
    x = 8'd17; y = 8'd3; dav1_ = 1'b0; dav2_ = 1'b0;
    wait_rfd(1'b0, 1'b0, "t6 cap");
    dav1_ = 1'b1; dav2_ = 1'b1; x = 'x; y = 'x;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t6 rfd", {rfd1, rfd2}, 3);
    check("t6 m", m, 0);
    repeat (15) @(negedge clock);
    check("t6 no ok", ok_count, base);
    run_pair(8'd6, 8'd7, 16'd42, "t6 6x7");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
